// File: rtl/game_flow_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | game_flow_ctrl_pkg : shared state encodings and sizing helpers     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package game_flow_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  localparam int HOLDOFF_DEFAULT = 60;
  localparam int BCD_W           = 4;

  // Hold counter only needs to reach HOLDOFF_TICKS-1.
  function automatic int hold_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_flow_ctrl_bcd_counter.sv
// +--------------------------------------------------------------------+
// | game_flow_ctrl_bcd_counter : saturating multi-digit BCD counter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module game_flow_ctrl_bcd_counter
  import game_flow_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      gameClk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      inc,
  output logic [BCD_W*DIGITS-1:0]   count
);

  logic [BCD_W*DIGITS-1:0] r_count;
  logic [BCD_W*DIGITS-1:0] w_next;
  logic [DIGITS:0]         w_carry;
  logic [DIGITS-1:0]       w_nine;
  logic                    w_sat;

  assign w_sat      = &w_nine;
  assign w_carry[0] = inc & ~w_sat;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [BCD_W-1:0] w_d;
      assign w_d            = r_count[i*BCD_W +: BCD_W];
      assign w_nine[i]      = (w_d == 4'd9);
      assign w_carry[i+1]   = w_carry[i] & w_nine[i];
      assign w_next[i*BCD_W +: BCD_W] = !w_carry[i] ? w_d :
                                        (w_nine[i] ? 4'd0 : w_d + 4'd1);
    end
  endgenerate

  always_ff @(posedge gameClk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/game_flow_ctrl.sv
// +--------------------------------------------------------------------+
// | game_flow_ctrl : round sequencer (flap pulses, hold-off, score)    |
// | Optional HIGH_SCORE_EN adds a best-score register. Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int HOLDOFF_TICKS = HOLDOFF_DEFAULT,
  parameter int SCORE_DIGITS  = 4
) (
  input  logic                            gameClk,
  input  logic                            reset,
  input  logic                            button,
  input  logic                            collision,
  input  logic                            pipe_passed,
  output logic [1:0]                      state,
  output logic                            finished,
  output logic                            bird_reset,
  output logic                            flap,
  output logic [BCD_W*SCORE_DIGITS-1:0]   score,
  output logic [BCD_W*SCORE_DIGITS-1:0]   high_score
);

  localparam int            HW          = hold_width(HOLDOFF_TICKS);
  localparam logic [HW-1:0] C_HOLD_LOAD = HW'(HOLDOFF_TICKS - 1);
  localparam int            SW          = BCD_W * SCORE_DIGITS;

  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;
  logic          r_btn_q;
  logic          r_finished;
  logic          r_bird_reset;
  logic          r_flap;

  logic          w_rise;
  logic [1:0]    w_state_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_flap_nxt;
  logic          w_bird_reset_nxt;
  logic          w_clear;
  logic          w_inc;
  logic          w_die;
  logic [SW-1:0] w_score;

  assign w_rise = button & ~r_btn_q;

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_flap_nxt       = 1'b0;
    w_bird_reset_nxt = 1'b0;
    w_clear          = 1'b0;
    w_inc            = 1'b0;
    w_die            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PLAYING;
          w_flap_nxt  = 1'b1;
          w_clear     = 1'b1;
        end
      end
      ST_PLAYING: begin
        // Collision dominates both a same-tick flap and a same-tick pipe pass.
        if (collision) begin
          w_state_nxt = ST_DEAD;
          w_hold_nxt  = C_HOLD_LOAD;
          w_die       = 1'b1;
        end else begin
          w_flap_nxt  = w_rise;
          w_inc       = pipe_passed;
        end
      end
      ST_DEAD: begin
        if (r_hold == '0) begin
          w_state_nxt = ST_OVER;
        end else begin
          w_hold_nxt  = r_hold - HW'(1);
        end
      end
      ST_OVER: begin
        if (w_rise) begin
          w_state_nxt      = ST_IDLE;
          w_bird_reset_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge gameClk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_btn_q      <= 1'b1;
      r_finished   <= 1'b0;
      r_bird_reset <= 1'b0;
      r_flap       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_btn_q      <= button;
      r_finished   <= (w_state_nxt == ST_DEAD) || (w_state_nxt == ST_OVER);
      r_bird_reset <= w_bird_reset_nxt;
      r_flap       <= w_flap_nxt;
    end
  end

  game_flow_ctrl_bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .gameClk (gameClk),
    .reset   (reset),
    .clear   (w_clear),
    .inc     (w_inc),
    .count   (w_score)
  );

`ifdef HIGH_SCORE_EN
  logic [SW-1:0] r_high;

  // Packed BCD compares correctly as plain unsigned binary.
  always_ff @(posedge gameClk) begin
    if (reset) begin
      r_high <= '0;
    end else if (w_die && (w_score > r_high)) begin
      r_high <= w_score;
    end
  end

  assign high_score = r_high;
`else
  assign high_score = '0;
`endif

  assign state      = r_state;
  assign finished   = r_finished;
  assign bird_reset = r_bird_reset;
  assign flap       = r_flap;
  assign score      = w_score;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_game_flow_ctrl : directed scoreboard bench for game_flow_ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_game_flow_ctrl;

  localparam int HOLD = 3;
  localparam int DIG  = 4;
  localparam int SW   = 4 * DIG;
  localparam int MAXS = 9999;

  logic          gameClk = 1'b0;
  logic          reset;
  logic          button;
  logic          collision;
  logic          pipe_passed;
  logic [1:0]    state;
  logic          finished;
  logic          bird_reset;
  logic          flap;
  logic [SW-1:0] score;
  logic [SW-1:0] high_score;

  game_flow_ctrl #(
    .HOLDOFF_TICKS (HOLD),
    .SCORE_DIGITS  (DIG)
  ) dut (
    .gameClk     (gameClk),
    .reset       (reset),
    .button      (button),
    .collision   (collision),
    .pipe_passed (pipe_passed),
    .state       (state),
    .finished    (finished),
    .bird_reset  (bird_reset),
    .flap        (flap),
    .score       (score),
    .high_score  (high_score)
  );

  always #5 gameClk = ~gameClk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_state = 0;
  int   m_hold  = 0;
  logic m_btnq  = 1'b1;
  logic m_fin   = 1'b0;
  logic m_br    = 1'b0;
  logic m_flap  = 1'b0;
  int   m_score = 0;
  int   m_hs    = 0;

  logic [36:0] exp_q[$];

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int exp_hs(input int v);
`ifdef HIGH_SCORE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic c, input logic p);
    logic rise;
    reset = r; button = b; collision = c; pipe_passed = p;
    if (r) begin
      m_state = 0; m_hold = 0; m_btnq = 1'b1; m_fin = 1'b0;
      m_br = 1'b0; m_flap = 1'b0; m_score = 0; m_hs = 0;
    end else begin
      rise   = b && !m_btnq;
      m_btnq = b;
      m_br   = 1'b0;
      m_flap = 1'b0;
      case (m_state)
        0: if (rise) begin m_state = 1; m_flap = 1'b1; m_score = 0; end
        1: begin
          if (c) begin
            if (m_score > m_hs) m_hs = exp_hs(m_score);
            m_state = 2;
            m_hold  = HOLD - 1;
          end else begin
            m_flap = rise;
            if (p && m_score < MAXS) m_score++;
          end
        end
        2: if (m_hold == 0) m_state = 3; else m_hold--;
        default: if (rise) begin m_state = 0; m_br = 1'b1; end
      endcase
      m_fin = (m_state >= 2);
    end
    exp_q.push_back({2'(m_state), m_fin, m_br, m_flap, bcd(m_score), bcd(m_hs)});
    @(posedge gameClk);
    #1;
    check("step", {state, finished, bird_reset, flap, score, high_score}, exp_q.pop_front());
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic die(input logic pp, input logic rise);
    logic b;
    step(1'b0, rise, 1'b1, pp);
    check("die_state", 37'(state), 37'(2));
    check("die_finished", 37'(finished), 37'(1));
    check("die_noflap", 37'(flap), 37'(0));
    b = rise;
    for (int i = 0; i < HOLD; i++) begin
      b = ~b;
      step(1'b0, b, 1'b0, 1'b0);
      check("holdoff_state", 37'(state), (i == HOLD - 1) ? 37'(3) : 37'(2));
    end
  endtask

  task automatic restart();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("over_to_idle", 37'(state), 37'(0));
    check("bird_reset_pulse", 37'(bird_reset), 37'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("bird_reset_one_tick", 37'(bird_reset), 37'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_flap", 37'(flap), 37'(1));
    check("start_score_clear", 37'(score), 37'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; button = 1'b1; collision = 1'b0; pipe_passed = 1'b0;

    // Button held through reset must not produce a start edge.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_state", 37'(state), 37'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_no_flap", 37'(flap), 37'(0));
    check("held_idle", 37'(state), 37'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("press_playing", 37'(state), 37'(1));
    check("press_flap", 37'(flap), 37'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("flap_one_tick", 37'(flap), 37'(0));

    // High-score rounds: 4, then 2 (same-tick pass), then 10.
    pulses(4);
    die(1'b0, 1'b0);
    check("hs_round1", 37'(high_score), 37'(bcd(exp_hs(4))));
    restart();
    pulses(2);
    die(1'b1, 1'b0);
    check("score_round2", 37'(score), 37'(16'h0002));
    check("hs_round2", 37'(high_score), 37'(bcd(exp_hs(4))));
    restart();
    pulses(10);
    check("score_0010", 37'(score), 37'(16'h0010));
    die(1'b0, 1'b0);
    check("hs_round3", 37'(high_score), 37'(bcd(exp_hs(10))));
    restart();

    // Collision with pipe pass and rise on the same tick.
    pulses(5);
    die(1'b1, 1'b1);
    check("score_0005_held", 37'(score), 37'(16'h0005));
    restart();

    // Counting and saturation.
    pulses(12);
    check("score_0012", 37'(score), 37'(16'h0012));
    pulses(MAXS - 12);
    check("score_9999", 37'(score), 37'(16'h9999));
    pulses(1);
    check("score_saturate", 37'(score), 37'(16'h9999));
    die(1'b0, 1'b0);
    restart();

    // Reset mid-round.
    pulses(7);
    check("score_0007", 37'(score), 37'(16'h0007));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("midreset_idle", 37'(state), 37'(0));
    check("midreset_score", 37'(score), 37'(0));
    check("midreset_finished", 37'(finished), 37'(0));
    check("midreset_bird_reset", 37'(bird_reset), 37'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
